// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with EX-side operand forwarding,
//               load-use hazard detection and a saturating bubble counter.
// Revision    : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_control,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [3:0]        ex_alu_control,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [REG_AW-1:0] C_X0      = '0;
    localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

    logic              r_valid;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_alu_src;
    logic [3:0]        r_alu_control;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_load_use;
    logic              w_insert_bubble;
    logic              w_capture;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;

    // The load in EX cannot supply its data until MEM/WB, so a dependent
    // instruction in decode must wait one cycle.
    assign w_load_use = r_valid && r_mem_read && (r_rd_addr != C_X0) && id_valid &&
                        ((r_rd_addr == id_rs1_addr) || (r_rd_addr == id_rs2_addr));

    // Flush dominates hold; hold dominates the load-use bubble.
    assign w_insert_bubble = flush || (!ex_hold && w_load_use);
    assign w_capture       = !flush && !ex_hold && !w_load_use;
    assign id_stall        = ex_hold || (w_load_use && !flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_rs1_addr    <= '0;
            r_rs2_addr    <= '0;
            r_rd_addr     <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_alu_src     <= 1'b0;
            r_alu_control <= 4'b0000;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else if (w_insert_bubble) begin
            r_valid       <= 1'b0;
            r_rs1_addr    <= '0;
            r_rs2_addr    <= '0;
            r_rd_addr     <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_alu_src     <= 1'b0;
            r_alu_control <= 4'b0000;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else if (w_capture) begin
            r_valid       <= id_valid;
            r_rs1_addr    <= id_rs1_addr;
            r_rs2_addr    <= id_rs2_addr;
            r_rd_addr     <= id_rd_addr;
            r_rs1_data    <= id_rs1_data;
            r_rs2_data    <= id_rs2_data;
            r_imm         <= id_imm;
            r_alu_src     <= id_alu_src;
            r_alu_control <= id_alu_control;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (w_insert_bubble && (r_bubble_count != C_CNT_MAX)) begin
            r_bubble_count <= r_bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // EX/MEM wins over MEM/WB because it holds the younger result; x0 is
    // hard-wired to zero and must never pick up a forwarded value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   regval
    );
        logic [XLEN-1:0] v;
        v = regval;
        if (mem_reg_write && (mem_rd_addr != C_X0) && (mem_rd_addr == rs)) begin
            v = mem_result;
        end else if (wb_reg_write && (wb_rd_addr != C_X0) && (wb_rd_addr == rs)) begin
            v = wb_result;
        end
        return v;
    endfunction

    always_comb begin
        w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1_data);
        w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2_data);
    end

    assign ex_valid       = r_valid;
    assign ex_a           = w_fwd_rs1;
    assign ex_b           = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data  = w_fwd_rs2;
    assign ex_alu_control = r_alu_control;
    assign ex_rd_addr     = r_rd_addr;
    assign ex_reg_write   = r_valid && r_reg_write;
    assign ex_mem_read    = r_valid && r_mem_read;
    assign ex_mem_write   = r_valid && r_mem_write;
    assign bubble_count   = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Testbench for id_ex_stage: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the stage.
module tb_id_ex_stage;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk, rst_n;
    logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_control;
    logic        flush, ex_hold;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd_addr;
    logic [CNT_W-1:0] bubble_count;

    int n_vec = 0;
    int n_err = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_hold(ex_hold),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural picture of the instruction occupying EX.
    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  alu;
        logic        rw, mr, mw;
    } ex_t;

    ex_t m;
    int  m_cnt;

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (rs == 0) return regval;
        if (mem_reg_write && mem_rd_addr == rs) return mem_result;
        if (wb_reg_write && wb_rd_addr == rs) return wb_result;
        return regval;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0;
        id_alu_control = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0; ex_hold = 0;
        mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic src, input logic [3:0] alu,
                             input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
        id_alu_control = alu; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic test_reset();
        set_instr(1, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 0, 0, 4'b0010, 1, 0, 0);
        step();
        flush = 1; step(); flush = 0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_a !== 32'h0 || bubble_count !== '0 || id_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: valid=%b a=%h cnt=%0d stall=%b, want 0/0/0/0",
                     ex_valid, ex_a, bubble_count, id_stall);
        end
        n_vec++;
        if (ex_b !== 32'h0 || ex_store_data !== 32'h0 || ex_alu_control !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_data: b=%h st=%h alu=%b, want 0/0/0000", ex_b, ex_store_data, ex_alu_control);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        #1;
    endtask

    task automatic test_exmem_fwd();
        apply_reset();
        set_instr(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 0, 0, 4'b0010, 1, 0, 0);
        step();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_a !== 32'h1 || ex_b !== 32'h2) begin
            n_err++;
            $display("FAIL add_capture: valid=%b a=%h b=%h, want 1/1/2", ex_valid, ex_a, ex_b);
        end
        set_instr(1, 5'd3, 5'd1, 5'd4, 32'hAAAA, 32'h1, 0, 0, 4'b0110, 1, 0, 0);
        mem_rd_addr = 5'd3; mem_reg_write = 1; mem_result = 32'h10;
        step();
        n_vec++;
        if (ex_a !== 32'h10 || ex_b !== 32'h1 || ex_alu_control !== 4'b0110 || ex_rd_addr !== 5'd4) begin
            n_err++;
            $display("FAIL exmem_fwd: a=%h b=%h alu=%b rd=%0d, want 10/1/0110/4",
                     ex_a, ex_b, ex_alu_control, ex_rd_addr);
        end
        clear_inputs();
    endtask

    task automatic test_fwd_priority();
        apply_reset();
        set_instr(1, 5'd7, 5'd8, 5'd9, 32'h777, 32'h888, 0, 0, 4'b0000, 1, 0, 0);
        mem_rd_addr = 5'd7; mem_reg_write = 1; mem_result = 32'h10;
        wb_rd_addr  = 5'd7; wb_reg_write  = 1; wb_result  = 32'h20;
        step();
        n_vec++;
        if (ex_a !== 32'h10) begin
            n_err++;
            $display("FAIL fwd_priority: a=%h, want 10", ex_a);
        end
        mem_reg_write = 0;
        #1;
        n_vec++;
        if (ex_a !== 32'h20 || ex_b !== 32'h888) begin
            n_err++;
            $display("FAIL wb_fwd: a=%h b=%h, want 20/888", ex_a, ex_b);
        end
        set_instr(1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 0, 0, 4'b0001, 1, 0, 0);
        mem_rd_addr = 5'd0; mem_reg_write = 1; mem_result = 32'h55;
        wb_rd_addr  = 5'd0; wb_reg_write  = 1; wb_result  = 32'h66;
        step();
        n_vec++;
        if (ex_a !== 32'h0 || ex_store_data !== 32'h0) begin
            n_err++;
            $display("FAIL x0_no_fwd: a=%h st=%h, want 0/0", ex_a, ex_store_data);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_instr(1, 5'd1, 5'd0, 5'd5, 32'h100, 0, 32'h4, 1, 4'b0010, 1, 1, 0);
        step();
        set_instr(1, 5'd5, 5'd5, 5'd6, 32'h5555, 32'h6666, 0, 0, 4'b0010, 1, 0, 0);
        #1;
        n_vec++;
        if (id_stall !== 1'b1) begin
            n_err++;
            $display("FAIL lu_stall: stall=%b, want 1", id_stall);
        end
        step();
        mem_rd_addr = 5'd5; mem_reg_write = 1; mem_result = 32'h0BAD;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || bubble_count !== 4'd1 || id_stall !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_err++;
            $display("FAIL lu_bubble: valid=%b cnt=%0d stall=%b rw=%b, want 0/1/0/0",
                     ex_valid, bubble_count, id_stall, ex_reg_write);
        end
        mem_rd_addr = 0; mem_reg_write = 0;
        wb_rd_addr = 5'd5; wb_reg_write = 1; wb_result = 32'hCAFEF00D;
        step();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_a !== 32'hCAFEF00D || ex_b !== 32'hCAFEF00D || bubble_count !== 4'd1) begin
            n_err++;
            $display("FAIL lu_consumer: valid=%b a=%h b=%h cnt=%0d, want 1/cafef00d/cafef00d/1",
                     ex_valid, ex_a, ex_b, bubble_count);
        end
        clear_inputs();
    endtask

    task automatic test_flush_hold();
        apply_reset();
        set_instr(1, 5'd1, 5'd0, 5'd5, 0, 0, 0, 1, 4'b0010, 1, 1, 0);
        step();
        set_instr(1, 5'd5, 5'd2, 5'd6, 32'h100, 32'h200, 0, 0, 4'b0010, 1, 0, 0);
        flush = 1;
        #1;
        n_vec++;
        if (id_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_lu_stall: stall=%b, want 0", id_stall);
        end
        step();
        flush = 0;
        n_vec++;
        if (ex_valid !== 1'b0 || bubble_count !== 4'd1 || ex_mem_read !== 1'b0) begin
            n_err++;
            $display("FAIL flush_bubble: valid=%b cnt=%0d mr=%b, want 0/1/0", ex_valid, bubble_count, ex_mem_read);
        end
        step();
        ex_hold = 1;
        for (int k = 0; k < 3; k++) begin
            set_instr(1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                      $urandom, $urandom, $urandom, 1, 4'b0111, 1, 1, 1);
            #1;
            n_vec++;
            if (id_stall !== 1'b1) begin
                n_err++;
                $display("FAIL hold_stall[%0d]: stall=%b, want 1", k, id_stall);
            end
            step();
            n_vec++;
            if (ex_valid !== 1'b1 || ex_a !== 32'h100 || ex_b !== 32'h200 || ex_rd_addr !== 5'd6 ||
                ex_alu_control !== 4'b0010 || bubble_count !== 4'd1) begin
                n_err++;
                $display("FAIL hold_frozen[%0d]: valid=%b a=%h b=%h rd=%0d alu=%b cnt=%0d, want 1/100/200/6/0010/1",
                         k, ex_valid, ex_a, ex_b, ex_rd_addr, ex_alu_control, bubble_count);
            end
        end
        clear_inputs();
    endtask

    task automatic test_imm_store();
        apply_reset();
        set_instr(1, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'hFFFFFFFC, 1, 4'b0010, 0, 0, 1);
        mem_rd_addr = 5'd2; mem_reg_write = 1; mem_result = 32'h99;
        step();
        n_vec++;
        if (ex_b !== 32'hFFFFFFFC || ex_store_data !== 32'h99 || ex_a !== 32'h11 || ex_mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL imm_store: b=%h st=%h a=%h mw=%b, want fffffffc/99/11/1",
                     ex_b, ex_store_data, ex_a, ex_mem_write);
        end
        set_instr(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 4'b0010, 1, 1, 1);
        step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
            ex_mem_write !== 1'b0 || bubble_count !== 4'd0) begin
            n_err++;
            $display("FAIL invalid_gate: valid=%b rw=%b mr=%b mw=%b cnt=%0d, want 0/0/0/0/0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, bubble_count);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        apply_reset();
        flush = 1;
        for (int k = 0; k < CMAX; k++) step();
        n_vec++;
        if (bubble_count !== CNT_W'(CMAX)) begin
            n_err++;
            $display("FAIL sat_reach: cnt=%0d, want %0d", bubble_count, CMAX);
        end
        step(); step();
        n_vec++;
        if (bubble_count !== CNT_W'(CMAX)) begin
            n_err++;
            $display("FAIL sat_hold: cnt=%0d, want %0d", bubble_count, CMAX);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [3:0]  ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        logic        lu, exp_stall, exp_rw, exp_mr, exp_mw;
        logic [31:0] exp_a, exp_b, exp_s;
        ex_t         bub;
        bub = '{default: 0};
        apply_reset();
        m = bub;
        m_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            set_instr($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            flush = $urandom_range(0, 9) == 0;
            ex_hold = $urandom_range(0, 6) == 0;
            mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom_range(0, 1));
            mem_result = $urandom;
            wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom_range(0, 1));
            wb_result = $urandom;
            #1;
            lu = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
            exp_stall = ex_hold || (lu && !flush);
            exp_a = ref_fwd(m.rs1, m.d1);
            exp_s = ref_fwd(m.rs2, m.d2);
            exp_b = m.src ? m.imm : exp_s;
            exp_rw = m.valid && m.rw;
            exp_mr = m.valid && m.mr;
            exp_mw = m.valid && m.mw;
            n_vec++;
            if ({id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !==
                {exp_stall, m.valid, exp_rw, exp_mr, exp_mw}) begin
                n_err++;
                $display("FAIL rand_ctrl[%0d]: stall,valid,rw,mr,mw=%b%b%b%b%b, want %b%b%b%b%b", i,
                         id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                         exp_stall, m.valid, exp_rw, exp_mr, exp_mw);
            end
            n_vec++;
            if (ex_a !== exp_a || ex_b !== exp_b || ex_store_data !== exp_s) begin
                n_err++;
                $display("FAIL rand_data[%0d]: a=%h b=%h st=%h, want %h/%h/%h", i,
                         ex_a, ex_b, ex_store_data, exp_a, exp_b, exp_s);
            end
            n_vec++;
            if (ex_alu_control !== m.alu || ex_rd_addr !== m.rd || bubble_count !== CNT_W'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_misc[%0d]: alu=%b rd=%0d cnt=%0d, want %b/%0d/%0d", i,
                         ex_alu_control, ex_rd_addr, bubble_count, m.alu, m.rd, m_cnt);
            end
            if (flush || (!ex_hold && lu)) begin
                m = bub;
                if (m_cnt < CMAX) m_cnt++;
            end else if (!ex_hold) begin
                m = '{valid: id_valid, rs1: id_rs1_addr, rs2: id_rs2_addr, rd: id_rd_addr,
                      d1: id_rs1_data, d2: id_rs2_data, imm: id_imm, src: id_alu_src,
                      alu: id_alu_control, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_exmem_fwd();
        test_fwd_priority();
        test_load_use();
        test_flush_hold();
        test_imm_store();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
